// File: rtl/gf180mcu_fd_sc_mcu9t5v0__orcap4_1.sv
// Sticky 4-input event capture: synchronise, edge-detect, latch flags, and drive
// a registered OR output with minimum hold and a clear/acknowledge handshake.
module gf180mcu_fd_sc_mcu9t5v0__orcap4_1 #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned MIN_HOLD    = 4,
   parameter int unsigned CNT_W       = 4
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             A1,
   input  logic             A2,
   input  logic             A3,
   input  logic             A4,
   input  logic             EN,
   input  logic             CLR,
   output logic             Z,
   output logic [3:0]       FLAGS,
   output logic             ACK,
   output logic [CNT_W-1:0] CNT
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACTIVE,
      S_HELD,
      S_CLEARING
   } state_t;

   localparam logic [3:0] HOLD_INIT = 4'(MIN_HOLD - 1);

   logic [3:0]       w_async;
   logic [3:0]       w_sync;
   logic [3:0]       w_rise;
   logic [3:0]       w_cap;
   logic             w_any;
   logic [CNT_W-1:0] w_cnt_inc;

   state_t           r_state, w_state_nxt;
   logic [3:0]       r_prev;
   logic [3:0]       r_flags, w_flags_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [3:0]       r_hold, w_hold_nxt;
   logic             r_z, w_z_nxt;
   logic             r_ack, w_ack_nxt;

   assign w_async = {A4, A3, A2, A1};

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign w_sync = w_async;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0][3:0] r_sync;
         always_ff @(posedge CLK or negedge RN) begin
            if (!RN) begin
               r_sync <= '0;
            end else begin
               r_sync[0] <= w_async;
               for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                  r_sync[k] <= r_sync[k-1];
               end
            end
         end
         assign w_sync = r_sync[SYNC_STAGES-1];
      end
   endgenerate

   // History tracks the synchronised inputs even while disabled, so re-enabling
   // with an input already high never looks like a new edge.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) r_prev <= '0;
      else     r_prev <= w_sync;
   end

   assign w_rise    = w_sync & ~r_prev;
   assign w_cap     = EN ? w_rise : '0;
   assign w_any     = |w_cap;
   assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         r_state <= S_IDLE;
         r_flags <= '0;
         r_cnt   <= '0;
         r_hold  <= '0;
         r_z     <= 1'b0;
         r_ack   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_flags <= w_flags_nxt;
         r_cnt   <= w_cnt_nxt;
         r_hold  <= w_hold_nxt;
         r_z     <= w_z_nxt;
         r_ack   <= w_ack_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_flags_nxt = r_flags;
      w_cnt_nxt   = r_cnt;
      w_hold_nxt  = r_hold;
      w_z_nxt     = r_z;
      w_ack_nxt   = 1'b0;
      case (r_state)
         S_IDLE, S_CLEARING: begin
            w_state_nxt = S_IDLE;
            if (w_any) begin
               w_state_nxt = S_ACTIVE;
               w_flags_nxt = w_cap;
               w_cnt_nxt   = w_cnt_inc;
               w_hold_nxt  = HOLD_INIT;
               w_z_nxt     = 1'b1;
            end
         end
         S_ACTIVE: begin
            w_flags_nxt = r_flags | w_cap;
            if (w_any) w_cnt_nxt = w_cnt_inc;
            if (r_hold == 4'd0) w_state_nxt = S_HELD;
            else                w_hold_nxt  = r_hold - 4'd1;
         end
         S_HELD: begin
            if (CLR) begin
               w_ack_nxt = 1'b1;
               // A capture coinciding with the clear survives it and restarts the hold.
               if (w_any) begin
                  w_state_nxt = S_ACTIVE;
                  w_flags_nxt = w_cap;
                  w_cnt_nxt   = CNT_W'(1);
                  w_hold_nxt  = HOLD_INIT;
                  w_z_nxt     = 1'b1;
               end else begin
                  w_state_nxt = S_CLEARING;
                  w_flags_nxt = '0;
                  w_cnt_nxt   = '0;
                  w_z_nxt     = 1'b0;
               end
            end else begin
               w_flags_nxt = r_flags | w_cap;
               if (w_any) w_cnt_nxt = w_cnt_inc;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign Z     = r_z;
   assign FLAGS = r_flags;
   assign ACK   = r_ack;
   assign CNT   = r_cnt;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__orcap4_1.sv
// Directed vector bench for the sticky 4-input event capture stage.
module tb_gf180mcu_fd_sc_mcu9t5v0__orcap4_1;

   logic       CLK = 1'b0;
   logic       RN, A1, A2, A3, A4, EN, CLR;
   logic       Z, ACK;
   logic [3:0] FLAGS;
   logic [3:0] CNT;

   int checks   = 0;
   int failures = 0;

   gf180mcu_fd_sc_mcu9t5v0__orcap4_1 #(
      .SYNC_STAGES(2),
      .MIN_HOLD(4),
      .CNT_W(4)
   ) dut (
      .CLK(CLK), .RN(RN), .A1(A1), .A2(A2), .A3(A3), .A4(A4),
      .EN(EN), .CLR(CLR), .Z(Z), .FLAGS(FLAGS), .ACK(ACK), .CNT(CNT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0] a;
      logic       en;
      logic       clr;
      logic       z;
      logic [3:0] f;
      logic [3:0] c;
      logic       ack;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic [3:0] a, input logic en, input logic clr,
                      input logic z, input logic [3:0] f, input logic [3:0] c,
                      input logic ack);
      vec_t v;
      v.a = a; v.en = en; v.clr = clr; v.z = z; v.f = f; v.c = c; v.ack = ack;
      vq.push_back(v);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] a);
      {A4, A3, A2, A1} = a;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   initial begin
      int exp_c;
      int caps;
      int z_exp;
      bit seen;

      RN = 1'b0; EN = 1'b1; CLR = 1'b0; drive(4'b0000);
      repeat (2) tick();
      chk("reset_z", Z, 0);
      chk("reset_flags", FLAGS, 0);
      chk("reset_cnt", CNT, 0);
      chk("reset_ack", ACK, 0);
      RN = 1'b1;

      // Single A2 pulse, clear requested early, honoured once HELD
      add(4'b0010,1,0, 0,4'b0000,0,0);
      add(4'b0010,1,0, 0,4'b0000,0,0);
      add(4'b0010,1,0, 1,4'b0010,1,0);
      add(4'b0000,1,1, 1,4'b0010,1,0);
      add(4'b0000,1,1, 1,4'b0010,1,0);
      add(4'b0000,1,1, 1,4'b0010,1,0);
      add(4'b0000,1,1, 1,4'b0010,1,0);
      add(4'b0000,1,1, 0,4'b0000,0,1);
      add(4'b0000,1,1, 0,4'b0000,0,0);
      add(4'b0000,1,0, 0,4'b0000,0,0);
      // A1+A3 together, A4 two cycles later; hold not reloaded
      add(4'b0101,1,0, 0,4'b0000,0,0);
      add(4'b0101,1,0, 0,4'b0000,0,0);
      add(4'b1101,1,0, 1,4'b0101,1,0);
      add(4'b1101,1,0, 1,4'b0101,1,0);
      add(4'b1101,1,0, 1,4'b1101,2,0);
      add(4'b1101,1,0, 1,4'b1101,2,0);
      add(4'b1101,1,1, 1,4'b1101,2,0);
      add(4'b1101,1,1, 0,4'b0000,0,1);
      add(4'b1101,1,0, 0,4'b0000,0,0);
      add(4'b0000,1,0, 0,4'b0000,0,0);
      add(4'b0000,1,0, 0,4'b0000,0,0);
      add(4'b0000,1,0, 0,4'b0000,0,0);
      // A1 toggling while disabled, then enabled with A1 static high
      for (int i = 0; i < 8; i++) add((i % 2 == 0) ? 4'b0001 : 4'b0000, 0,0, 0,4'b0000,0,0);
      for (int i = 0; i < 4; i++) add(4'b0001,0,0, 0,4'b0000,0,0);
      for (int i = 0; i < 4; i++) add(4'b0001,1,0, 0,4'b0000,0,0);
      for (int i = 0; i < 3; i++) add(4'b0000,1,0, 0,4'b0000,0,0);
      // Clear in HELD coinciding with an A2 capture, then CLR held high
      add(4'b0001,1,0, 0,4'b0000,0,0);
      add(4'b0000,1,0, 0,4'b0000,0,0);
      add(4'b0000,1,0, 1,4'b0001,1,0);
      add(4'b0000,1,0, 1,4'b0001,1,0);
      add(4'b0000,1,0, 1,4'b0001,1,0);
      add(4'b0010,1,0, 1,4'b0001,1,0);
      add(4'b0010,1,0, 1,4'b0001,1,0);
      add(4'b0010,1,1, 1,4'b0010,1,1);
      add(4'b0010,1,1, 1,4'b0010,1,0);
      add(4'b0010,1,1, 1,4'b0010,1,0);
      add(4'b0010,1,1, 1,4'b0010,1,0);
      add(4'b0010,1,1, 1,4'b0010,1,0);
      add(4'b0010,1,1, 0,4'b0000,0,1);
      add(4'b0010,1,1, 0,4'b0000,0,0);
      add(4'b0000,1,1, 0,4'b0000,0,0);
      add(4'b0000,1,0, 0,4'b0000,0,0);
      add(4'b0000,1,0, 0,4'b0000,0,0);
      add(4'b0000,1,0, 0,4'b0000,0,0);

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].a); EN = vq[i].en; CLR = vq[i].clr;
         tick();
         chk($sformatf("vec[%0d] {Z,FLAGS,CNT,ACK}", i),
             {Z, FLAGS, CNT, ACK}, {vq[i].z, vq[i].f, vq[i].c, vq[i].ack});
      end

      // 20 A1 pulses: count saturates at 15, Z stays high
      EN = 1'b1; CLR = 1'b0;
      for (int t = 1; t <= 43; t++) begin
         drive((t <= 40 && (t % 2 == 1)) ? 4'b0001 : 4'b0000);
         tick();
         caps  = (t >= 3) ? (((t - 1) / 2 > 20) ? 20 : (t - 1) / 2) : 0;
         exp_c = (caps > 15) ? 15 : caps;
         z_exp = (t >= 3) ? 1 : 0;
         chk($sformatf("sat t=%0d {Z,FLAGS,CNT}", t), {Z, FLAGS, CNT},
             {z_exp[0], (t >= 3) ? 4'b0001 : 4'b0000, exp_c[3:0]});
      end
      CLR = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         tick();
         if (ACK) seen = 1'b1;
      end
      chk("sat_clear_ack_seen", seen, 1);
      chk("sat_clear {Z,FLAGS,CNT}", {Z, FLAGS, CNT}, 0);
      CLR = 1'b0;
      repeat (2) tick();

      // Asynchronous reset in ACTIVE with hold count 2; A3 high at release
      drive(4'b0001); tick();
      drive(4'b0000); tick();
      tick();
      tick();
      chk("pre_reset {Z,FLAGS,CNT}", {Z, FLAGS, CNT}, {1'b1, 4'b0001, 4'd1});
      #3;
      RN = 1'b0; drive(4'b0100);
      #1;
      chk("async_reset {Z,FLAGS,CNT,ACK}", {Z, FLAGS, CNT, ACK}, 0);
      tick();
      RN = 1'b1;
      tick();
      chk("rel_e1 FLAGS", FLAGS, 0);
      tick();
      chk("rel_e2 FLAGS", FLAGS, 0);
      tick();
      chk("rel_e3 {Z,FLAGS,CNT,ACK}", {Z, FLAGS, CNT, ACK}, {1'b1, 4'b0100, 4'd1, 1'b0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
